// File: rtl/qpu_itcm_arbt.sv
// ITCM ICB arbiter: shares the single-outstanding ITCM port between the IFU fetch
// path and the external loader/debug port, and routes each response to its owner.
module qpu_itcm_arbt #(
  parameter int AW         = 16,
  parameter int DW         = 64,
  parameter int MW         = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          ifu_icb_cmd_valid,
  output logic          ifu_icb_cmd_ready,
  input  logic [AW-1:0] ifu_icb_cmd_addr,
  output logic          ifu_icb_rsp_valid,
  input  logic          ifu_icb_rsp_ready,
  output logic [DW-1:0] ifu_icb_rsp_rdata,
  output logic          ifu_holdup,

  input  logic          ext_icb_cmd_valid,
  output logic          ext_icb_cmd_ready,
  input  logic          ext_icb_cmd_read,
  input  logic [AW-1:0] ext_icb_cmd_addr,
  input  logic [DW-1:0] ext_icb_cmd_wdata,
  input  logic [MW-1:0] ext_icb_cmd_wmask,
  output logic          ext_icb_rsp_valid,
  input  logic          ext_icb_rsp_ready,
  output logic [DW-1:0] ext_icb_rsp_rdata,
  input  logic          ext_lock,

  output logic          itcm_icb_cmd_valid,
  input  logic          itcm_icb_cmd_ready,
  output logic          itcm_icb_cmd_read,
  output logic [AW-1:0] itcm_icb_cmd_addr,
  output logic [DW-1:0] itcm_icb_cmd_wdata,
  output logic [MW-1:0] itcm_icb_cmd_wmask,
  input  logic          itcm_icb_rsp_valid,
  output logic          itcm_icb_rsp_ready,
  input  logic [DW-1:0] itcm_icb_rsp_rdata,

  output logic          arbt_active
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  localparam logic       SEL_IFU = 1'b0;
  localparam logic       SEL_EXT = 1'b1;
  localparam logic [3:0] LIM     = 4'(STARVE_LIM);

  logic [0:0] r_state;
  logic       r_owner;
  logic       r_gnt_hold;
  logic       r_gnt_sel;
  logic [3:0] r_starve_cnt;
  logic       r_ifu_holdup;

  logic       w_idle;
  logic       w_pri_sel;
  logic       w_sel;
  logic       w_sel_valid;
  logic       w_cmd_hs;
  logic       w_rsp_hs;
  logic       w_stall;

  assign w_idle = (r_state == ST_IDLE);

  // Fixed priority: lock, then starvation relief, then IFU, else ext.
  always_comb begin
    w_pri_sel = SEL_EXT;
    if (ext_lock) begin
      w_pri_sel = SEL_EXT;
    end else if (ext_icb_cmd_valid && (r_starve_cnt == LIM)) begin
      w_pri_sel = SEL_EXT;
    end else if (ifu_icb_cmd_valid) begin
      w_pri_sel = SEL_IFU;
    end else begin
      w_pri_sel = SEL_EXT;
    end
  end

  // A stalled command keeps its grant so the downstream fields stay stable.
  assign w_sel       = r_gnt_hold ? r_gnt_sel : w_pri_sel;
  assign w_sel_valid = (w_sel == SEL_EXT) ? ext_icb_cmd_valid : ifu_icb_cmd_valid;

  assign itcm_icb_cmd_valid = w_idle & w_sel_valid;
  assign itcm_icb_cmd_read  = (w_sel == SEL_EXT) ? ext_icb_cmd_read  : 1'b1;
  assign itcm_icb_cmd_addr  = (w_sel == SEL_EXT) ? ext_icb_cmd_addr  : ifu_icb_cmd_addr;
  assign itcm_icb_cmd_wdata = (w_sel == SEL_EXT) ? ext_icb_cmd_wdata : {DW{1'b0}};
  assign itcm_icb_cmd_wmask = (w_sel == SEL_EXT) ? ext_icb_cmd_wmask : {MW{1'b0}};

  assign ifu_icb_cmd_ready = w_idle & (w_sel == SEL_IFU) & itcm_icb_cmd_ready;
  assign ext_icb_cmd_ready = w_idle & (w_sel == SEL_EXT) & itcm_icb_cmd_ready;

  assign w_cmd_hs = itcm_icb_cmd_valid & itcm_icb_cmd_ready;
  assign w_stall  = itcm_icb_cmd_valid & ~itcm_icb_cmd_ready;

  // Responses go only to the owner; anything arriving while idle is dropped.
  assign ifu_icb_rsp_valid  = ~w_idle & (r_owner == SEL_IFU) & itcm_icb_rsp_valid;
  assign ext_icb_rsp_valid  = ~w_idle & (r_owner == SEL_EXT) & itcm_icb_rsp_valid;
  assign ifu_icb_rsp_rdata  = itcm_icb_rsp_rdata;
  assign ext_icb_rsp_rdata  = itcm_icb_rsp_rdata;
  assign itcm_icb_rsp_ready = ~w_idle &
                              ((r_owner == SEL_EXT) ? ext_icb_rsp_ready : ifu_icb_rsp_ready);
  assign w_rsp_hs           = itcm_icb_rsp_valid & itcm_icb_rsp_ready;

  assign ifu_holdup  = r_ifu_holdup;
  assign arbt_active = ifu_icb_cmd_valid | ext_icb_cmd_valid | (r_state == ST_WAIT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_owner    <= SEL_IFU;
      r_gnt_hold <= 1'b0;
      r_gnt_sel  <= SEL_IFU;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_gnt_hold <= w_stall;
          if (w_stall) begin
            r_gnt_sel <= w_sel;
          end
          if (w_cmd_hs) begin
            r_owner <= w_sel;
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_rsp_hs) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Starvation count and IFU data-holdup both follow command handshakes only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve_cnt <= 4'd0;
      r_ifu_holdup <= 1'b0;
    end else if (w_cmd_hs) begin
      if (w_sel == SEL_EXT) begin
        r_starve_cnt <= 4'd0;
        r_ifu_holdup <= 1'b0;
      end else begin
        r_ifu_holdup <= 1'b1;
        if (ext_icb_cmd_valid && (r_starve_cnt < LIM)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_qpu_itcm_arbt.sv
// Directed self-checking bench for qpu_itcm_arbt: routing, priority, starvation,
// grant hold, loader lock and reset-during-response behaviour.
module tb_qpu_itcm_arbt;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MW = 8;

  logic          clk;
  logic          rst_n;
  logic          ifu_icb_cmd_valid;
  logic          ifu_icb_cmd_ready;
  logic [AW-1:0] ifu_icb_cmd_addr;
  logic          ifu_icb_rsp_valid;
  logic          ifu_icb_rsp_ready;
  logic [DW-1:0] ifu_icb_rsp_rdata;
  logic          ifu_holdup;
  logic          ext_icb_cmd_valid;
  logic          ext_icb_cmd_ready;
  logic          ext_icb_cmd_read;
  logic [AW-1:0] ext_icb_cmd_addr;
  logic [DW-1:0] ext_icb_cmd_wdata;
  logic [MW-1:0] ext_icb_cmd_wmask;
  logic          ext_icb_rsp_valid;
  logic          ext_icb_rsp_ready;
  logic [DW-1:0] ext_icb_rsp_rdata;
  logic          ext_lock;
  logic          itcm_icb_cmd_valid;
  logic          itcm_icb_cmd_ready;
  logic          itcm_icb_cmd_read;
  logic [AW-1:0] itcm_icb_cmd_addr;
  logic [DW-1:0] itcm_icb_cmd_wdata;
  logic [MW-1:0] itcm_icb_cmd_wmask;
  logic          itcm_icb_rsp_valid;
  logic          itcm_icb_rsp_ready;
  logic [DW-1:0] itcm_icb_rsp_rdata;
  logic          arbt_active;

  int checks   = 0;
  int failures = 0;

  qpu_itcm_arbt #(.AW(AW), .DW(DW), .MW(MW), .STARVE_LIM(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_icb_cmd_valid(ifu_icb_cmd_valid), .ifu_icb_cmd_ready(ifu_icb_cmd_ready),
    .ifu_icb_cmd_addr(ifu_icb_cmd_addr), .ifu_icb_rsp_valid(ifu_icb_rsp_valid),
    .ifu_icb_rsp_ready(ifu_icb_rsp_ready), .ifu_icb_rsp_rdata(ifu_icb_rsp_rdata),
    .ifu_holdup(ifu_holdup),
    .ext_icb_cmd_valid(ext_icb_cmd_valid), .ext_icb_cmd_ready(ext_icb_cmd_ready),
    .ext_icb_cmd_read(ext_icb_cmd_read), .ext_icb_cmd_addr(ext_icb_cmd_addr),
    .ext_icb_cmd_wdata(ext_icb_cmd_wdata), .ext_icb_cmd_wmask(ext_icb_cmd_wmask),
    .ext_icb_rsp_valid(ext_icb_rsp_valid), .ext_icb_rsp_ready(ext_icb_rsp_ready),
    .ext_icb_rsp_rdata(ext_icb_rsp_rdata), .ext_lock(ext_lock),
    .itcm_icb_cmd_valid(itcm_icb_cmd_valid), .itcm_icb_cmd_ready(itcm_icb_cmd_ready),
    .itcm_icb_cmd_read(itcm_icb_cmd_read), .itcm_icb_cmd_addr(itcm_icb_cmd_addr),
    .itcm_icb_cmd_wdata(itcm_icb_cmd_wdata), .itcm_icb_cmd_wmask(itcm_icb_cmd_wmask),
    .itcm_icb_rsp_valid(itcm_icb_rsp_valid), .itcm_icb_rsp_ready(itcm_icb_rsp_ready),
    .itcm_icb_rsp_rdata(itcm_icb_rsp_rdata), .arbt_active(arbt_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge; inputs change and outputs are sampled there.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifu_icb_cmd_valid = 1'b0; ifu_icb_cmd_addr = '0; ifu_icb_rsp_ready = 1'b0;
    ext_icb_cmd_valid = 1'b0; ext_icb_cmd_read = 1'b1; ext_icb_cmd_addr = '0;
    ext_icb_cmd_wdata = '0; ext_icb_cmd_wmask = '0; ext_icb_rsp_ready = 1'b0;
    ext_lock = 1'b0; itcm_icb_cmd_ready = 1'b0; itcm_icb_rsp_valid = 1'b0;
    itcm_icb_rsp_rdata = '0;
    tick(); tick();
    checks++; if (dut.r_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.r_state); end
    checks++; if (dut.r_starve_cnt !== 4'd0) begin failures++; $display("FAIL reset_starve got=%0d exp=0", dut.r_starve_cnt); end
    checks++; if (ifu_holdup !== 1'b0) begin failures++; $display("FAIL reset_holdup got=%b exp=0", ifu_holdup); end
    checks++; if ({itcm_icb_cmd_valid, ifu_icb_cmd_ready, ext_icb_cmd_ready} !== 3'b000) begin
      failures++; $display("FAIL reset_cmd got=%b exp=000", {itcm_icb_cmd_valid, ifu_icb_cmd_ready, ext_icb_cmd_ready}); end
    checks++; if ({ifu_icb_rsp_valid, ext_icb_rsp_valid, itcm_icb_rsp_ready, arbt_active} !== 4'b0000) begin
      failures++; $display("FAIL reset_rsp got=%b exp=0000", {ifu_icb_rsp_valid, ext_icb_rsp_valid, itcm_icb_rsp_ready, arbt_active}); end
    rst_n = 1'b1;
    $display("txn reset done");
  endtask

  task automatic test_ifu_read();
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 16'h0010; itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if ({itcm_icb_cmd_valid, itcm_icb_cmd_read, ifu_icb_cmd_ready, ext_icb_cmd_ready} !== 4'b1110) begin
      failures++; $display("FAIL ifu_cmd_ctl got=%b exp=1110", {itcm_icb_cmd_valid, itcm_icb_cmd_read, ifu_icb_cmd_ready, ext_icb_cmd_ready}); end
    checks++; if (itcm_icb_cmd_addr !== 16'h0010) begin failures++; $display("FAIL ifu_cmd_addr got=%h exp=0010", itcm_icb_cmd_addr); end
    checks++; if ({itcm_icb_cmd_wdata, itcm_icb_cmd_wmask} !== 72'd0) begin
      failures++; $display("FAIL ifu_cmd_wr got=%h/%h exp=0/0", itcm_icb_cmd_wdata, itcm_icb_cmd_wmask); end
    tick();
    itcm_icb_rsp_valid = 1'b1; itcm_icb_rsp_rdata = 64'hDEAD_BEEF_0000_0001; ifu_icb_rsp_ready = 1'b1;
    #1;
    checks++; if ({ifu_icb_cmd_ready, itcm_icb_cmd_valid} !== 2'b00) begin
      failures++; $display("FAIL ifu_wait_block got=%b exp=00", {ifu_icb_cmd_ready, itcm_icb_cmd_valid}); end
    checks++; if ({ifu_icb_rsp_valid, ext_icb_rsp_valid, itcm_icb_rsp_ready} !== 3'b101) begin
      failures++; $display("FAIL ifu_rsp_route got=%b exp=101", {ifu_icb_rsp_valid, ext_icb_rsp_valid, itcm_icb_rsp_ready}); end
    checks++; if (ifu_icb_rsp_rdata !== 64'hDEAD_BEEF_0000_0001) begin
      failures++; $display("FAIL ifu_rsp_rdata got=%h exp=deadbeef00000001", ifu_icb_rsp_rdata); end
    checks++; if (ifu_holdup !== 1'b1) begin failures++; $display("FAIL ifu_holdup_set got=%b exp=1", ifu_holdup); end
    tick();
    itcm_icb_rsp_valid = 1'b0;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin failures++; $display("FAIL ifu_second_accept got=%b exp=1", ifu_icb_cmd_ready); end
    ifu_icb_cmd_valid = 1'b0; ifu_icb_rsp_ready = 1'b0;
    $display("txn ifu read addr=0010 rdata=%h", ifu_icb_rsp_rdata);
  endtask

  task automatic test_ext_write();
    ext_icb_cmd_valid = 1'b1; ext_icb_cmd_read = 1'b0; ext_icb_cmd_addr = 16'h0020;
    ext_icb_cmd_wdata = 64'h1122334455667788; ext_icb_cmd_wmask = 8'h0F; itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if ({itcm_icb_cmd_valid, itcm_icb_cmd_read, ext_icb_cmd_ready, ifu_icb_cmd_ready} !== 4'b1010) begin
      failures++; $display("FAIL ext_cmd_ctl got=%b exp=1010", {itcm_icb_cmd_valid, itcm_icb_cmd_read, ext_icb_cmd_ready, ifu_icb_cmd_ready}); end
    checks++; if ({itcm_icb_cmd_addr, itcm_icb_cmd_wdata, itcm_icb_cmd_wmask} !== {16'h0020, 64'h1122334455667788, 8'h0F}) begin
      failures++; $display("FAIL ext_cmd_fields got=%h/%h/%h exp=0020/1122334455667788/0f", itcm_icb_cmd_addr, itcm_icb_cmd_wdata, itcm_icb_cmd_wmask); end
    checks++; if (ifu_holdup !== 1'b1) begin failures++; $display("FAIL ext_holdup_before got=%b exp=1", ifu_holdup); end
    tick();
    ext_icb_cmd_valid = 1'b0; itcm_icb_rsp_valid = 1'b1; itcm_icb_rsp_rdata = 64'h0; ext_icb_rsp_ready = 1'b1;
    #1;
    checks++; if ({ext_icb_rsp_valid, ifu_icb_rsp_valid, itcm_icb_rsp_ready} !== 3'b101) begin
      failures++; $display("FAIL ext_rsp_route got=%b exp=101", {ext_icb_rsp_valid, ifu_icb_rsp_valid, itcm_icb_rsp_ready}); end
    checks++; if (ifu_holdup !== 1'b0) begin failures++; $display("FAIL ext_holdup_clear got=%b exp=0", ifu_holdup); end
    tick();
    itcm_icb_rsp_valid = 1'b0; ext_icb_rsp_ready = 1'b0; ext_icb_cmd_read = 1'b1;
    $display("txn ext write addr=0020 wmask=0f");
  endtask

  task automatic test_starvation();
    int  cnt;
    bit  exp_ext;
    cnt = 0;
    ifu_icb_cmd_valid = 1'b1; ext_icb_cmd_valid = 1'b1; itcm_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      exp_ext = (cnt == 4);
      checks++; if ({ext_icb_cmd_ready, ifu_icb_cmd_ready} !== {exp_ext, !exp_ext}) begin
        failures++; $display("FAIL starve_grant%0d got=%b exp=%b", i, {ext_icb_cmd_ready, ifu_icb_cmd_ready}, {exp_ext, !exp_ext}); end
      tick();
      if (exp_ext) cnt = 0; else if (cnt < 4) cnt = cnt + 1;
      itcm_icb_rsp_valid = 1'b1; ifu_icb_rsp_ready = 1'b1; ext_icb_rsp_ready = 1'b1;
      #1;
      checks++; if (dut.r_starve_cnt !== 4'(cnt)) begin
        failures++; $display("FAIL starve_cnt%0d got=%0d exp=%0d", i, dut.r_starve_cnt, cnt); end
      checks++; if ({ifu_icb_rsp_valid, ext_icb_rsp_valid} !== (exp_ext ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL starve_rsp%0d got=%b exp=%b", i, {ifu_icb_rsp_valid, ext_icb_rsp_valid}, (exp_ext ? 2'b01 : 2'b10)); end
      $display("txn starve %0d grant=%s cnt=%0d", i, exp_ext ? "EXT" : "IFU", cnt);
      tick();
      itcm_icb_rsp_valid = 1'b0;
    end
    ifu_icb_cmd_valid = 1'b0; ext_icb_cmd_valid = 1'b0;
    ifu_icb_rsp_ready = 1'b0; ext_icb_rsp_ready = 1'b0;
  endtask

  task automatic test_grant_hold();
    ext_icb_cmd_valid = 1'b1; ext_icb_cmd_read = 1'b1; ext_icb_cmd_addr = 16'h0123;
    ifu_icb_cmd_valid = 1'b0; itcm_icb_cmd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin
        ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 16'h0456;
      end
      #1;
      checks++; if ({itcm_icb_cmd_valid, itcm_icb_cmd_addr, ext_icb_cmd_ready, ifu_icb_cmd_ready} !== {1'b1, 16'h0123, 2'b00}) begin
        failures++; $display("FAIL hold_cycle%0d got=%b/%h/%b%b exp=1/0123/00", c, itcm_icb_cmd_valid, itcm_icb_cmd_addr, ext_icb_cmd_ready, ifu_icb_cmd_ready); end
      tick();
    end
    itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if ({ext_icb_cmd_ready, ifu_icb_cmd_ready, itcm_icb_cmd_addr} !== {2'b10, 16'h0123}) begin
      failures++; $display("FAIL hold_release got=%b%b/%h exp=10/0123", ext_icb_cmd_ready, ifu_icb_cmd_ready, itcm_icb_cmd_addr); end
    tick();
    ext_icb_cmd_valid = 1'b0; itcm_icb_rsp_valid = 1'b1; ext_icb_rsp_ready = 1'b1;
    #1;
    checks++; if (ext_icb_rsp_valid !== 1'b1) begin failures++; $display("FAIL hold_ext_rsp got=%b exp=1", ext_icb_rsp_valid); end
    tick();
    itcm_icb_rsp_valid = 1'b0; ext_icb_rsp_ready = 1'b0;
    #1;
    checks++; if ({ifu_icb_cmd_ready, itcm_icb_cmd_addr} !== {1'b1, 16'h0456}) begin
      failures++; $display("FAIL hold_ifu_after got=%b/%h exp=1/0456", ifu_icb_cmd_ready, itcm_icb_cmd_addr); end
    ifu_icb_cmd_valid = 1'b0;
    $display("txn grant hold ext addr=0123 then ifu addr=0456");
  endtask

  task automatic test_ext_lock();
    int ifu_seen;
    ifu_seen = 0;
    ext_lock = 1'b1; ifu_icb_cmd_valid = 1'b1; ext_icb_cmd_valid = 1'b1; itcm_icb_cmd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (ifu_icb_cmd_ready) ifu_seen++;
      checks++; if (ext_icb_cmd_ready !== 1'b1) begin
        failures++; $display("FAIL lock_grant%0d got=%b exp=1", i, ext_icb_cmd_ready); end
      tick();
      itcm_icb_rsp_valid = 1'b1; ext_icb_rsp_ready = 1'b1; ifu_icb_rsp_ready = 1'b1;
      #1;
      if (ifu_icb_cmd_ready) ifu_seen++;
      checks++; if ({ext_icb_rsp_valid, ifu_icb_rsp_valid} !== 2'b10) begin
        failures++; $display("FAIL lock_rsp%0d got=%b exp=10", i, {ext_icb_rsp_valid, ifu_icb_rsp_valid}); end
      $display("txn lock %0d grant=EXT", i);
      tick();
      itcm_icb_rsp_valid = 1'b0;
    end
    checks++; if (ifu_seen !== 0) begin failures++; $display("FAIL lock_ifu_ready got=%0d exp=0", ifu_seen); end
    ext_lock = 1'b0; ifu_icb_cmd_valid = 1'b0; ext_icb_cmd_valid = 1'b0;
    ext_icb_rsp_ready = 1'b0; ifu_icb_rsp_ready = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    ifu_icb_cmd_valid = 1'b1; ifu_icb_cmd_addr = 16'h0040; ext_icb_cmd_valid = 1'b1; itcm_icb_cmd_ready = 1'b1;
    #1;
    checks++; if (ifu_icb_cmd_ready !== 1'b1) begin failures++; $display("FAIL rstw_grant got=%b exp=1", ifu_icb_cmd_ready); end
    tick();
    ifu_icb_cmd_valid = 1'b0; ext_icb_cmd_valid = 1'b0;
    #1;
    checks++; if ({dut.r_state, dut.r_starve_cnt} !== {1'b1, 4'd1}) begin
      failures++; $display("FAIL rstw_pre got=%0d/%0d exp=1/1", dut.r_state, dut.r_starve_cnt); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; itcm_icb_rsp_valid = 1'b1; ifu_icb_rsp_ready = 1'b1; ext_icb_rsp_ready = 1'b1;
    #1;
    checks++; if ({ifu_icb_rsp_valid, ext_icb_rsp_valid, itcm_icb_rsp_ready} !== 3'b000) begin
      failures++; $display("FAIL rstw_stray got=%b exp=000", {ifu_icb_rsp_valid, ext_icb_rsp_valid, itcm_icb_rsp_ready}); end
    checks++; if ({dut.r_state, dut.r_starve_cnt, ifu_holdup} !== {1'b0, 4'd0, 1'b0}) begin
      failures++; $display("FAIL rstw_state got=%0d/%0d/%b exp=0/0/0", dut.r_state, dut.r_starve_cnt, ifu_holdup); end
    tick();
    checks++; if (dut.r_state !== 1'b0) begin failures++; $display("FAIL rstw_idle_after got=%0d exp=0", dut.r_state); end
    itcm_icb_rsp_valid = 1'b0; ifu_icb_rsp_ready = 1'b0; ext_icb_rsp_ready = 1'b0;
    $display("txn reset during wait, stray response ignored");
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_ext_write();
    test_starvation();
    test_grant_hold();
    test_ext_lock();
    test_reset_in_wait();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/qpu_itcm_arbt.md
Name: qpu_itcm_arbt

Overview:
Two-port arbiter in front of the ITCM SRAM ICB controller. It shares the single-outstanding ITCM ICB port between the IFU fetch path and an external loader/debug port (the program-download path).
- IFU has default priority.
- A starvation counter and a loader lock guarantee forward progress for the loader.
- Responses are routed back to the owner of the outstanding command.
- It also generates ifu_holdup, which tells the IFU whether the SRAM output still holds the IFU's last read data.

Parameters:
AW, 16, ICB address width (matches ITCM address width)
DW, 64, ICB data width
MW, 8, write-mask width (DW/8)
STARVE_LIM, 4, consecutive IFU grants allowed while ext is pending before ext is forced through (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; synchronous, active-low
ifu_icb_cmd_valid  in  1  IFU command valid
ifu_icb_cmd_ready  out  1  IFU command accepted
ifu_icb_cmd_addr  in  AW  IFU address (IFU is read-only; read forced 1, wdata/wmask forced 0 downstream)
ifu_icb_rsp_valid  out  1  IFU response valid
ifu_icb_rsp_ready  in  1  IFU response ready
ifu_icb_rsp_rdata  out  DW  IFU response data
ifu_holdup  out  1  SRAM output still holds the IFU's last read
ext_icb_cmd_valid  in  1  loader command valid
ext_icb_cmd_ready  out  1  loader command accepted
ext_icb_cmd_read  in  1  loader read(1)/write(0)
ext_icb_cmd_addr  in  AW  loader address
ext_icb_cmd_wdata  in  DW  loader write data
ext_icb_cmd_wmask  in  MW  loader byte mask
ext_icb_rsp_valid  out  1  loader response valid
ext_icb_rsp_ready  in  1  loader response ready
ext_icb_rsp_rdata  out  DW  loader response data
ext_lock  in  1  block all IFU grants (program load in progress)
itcm_icb_cmd_valid  out  1  to ITCM ctrl
itcm_icb_cmd_ready  in  1  from ITCM ctrl
itcm_icb_cmd_read  out  1  muxed read
itcm_icb_cmd_addr  out  AW  muxed address
itcm_icb_cmd_wdata  out  DW  muxed wdata
itcm_icb_cmd_wmask  out  MW  muxed wmask
itcm_icb_rsp_valid  in  1  from ITCM ctrl
itcm_icb_rsp_ready  out  1  to ITCM ctrl
itcm_icb_rsp_rdata  in  DW  from ITCM ctrl
arbt_active  out  1  any valid pending or a transaction outstanding (feeds clock-gate enable)

Behaviour:
Interface:
- Single clock clk.
- Reset rst_n is synchronous and active-low; all state is cleared on the rising edge of clk while rst_n=0.

State machine (state reg):
- IDLE: grant is computed combinationally from the request valids. Selected fields are muxed to itcm_icb_cmd_*, itcm_icb_cmd_valid = selected valid, and the selected requester's cmd_ready = itcm_icb_cmd_ready. The non-selected requester's cmd_ready = 0.
  - On itcm cmd handshake: owner <= selected requester; go to WAIT_RSP.
  - If itcm_icb_cmd_valid=1 and itcm_icb_cmd_ready=0: grant is latched (gnt_hold=1, gnt_sel registered) and held until the handshake. A later-arriving higher-priority request must not change the muxed fields.
- WAIT_RSP: itcm_icb_cmd_valid=0 and both cmd_ready=0 (single outstanding).
  - itcm_icb_rsp_* is routed to the owner only; the other port's rsp_valid=0.
  - itcm_icb_rsp_ready = owner's rsp_ready.
  - On rsp handshake: go to IDLE. The next command is accepted no earlier than the following cycle, so peak throughput is 1 per 2 cycles.
- Stray itcm_icb_rsp_valid in IDLE: ignored; itcm_icb_rsp_ready=0 in IDLE.

Grant priority (IDLE, no hold), highest first:
- ext_lock=1: ext only.
- ext valid and starve_cnt==STARVE_LIM: ext.
- IFU valid: IFU.
- Otherwise ext.

Starvation counter (starve_cnt, 4 bits):
- +1 on an IFU cmd handshake while ext_icb_cmd_valid=1, saturating at STARVE_LIM.
- Cleared to 0 on any ext cmd handshake.

ifu_holdup:
- Set on an IFU cmd handshake.
- Cleared on an ext cmd handshake.

arbt_active: = ifu valid | ext valid | (state==WAIT_RSP).

Reset values:
- state=IDLE, owner=IFU, gnt_hold=0, starve_cnt=0, ifu_holdup=0.
- All valid/ready outputs are 0 except as driven combinationally by inputs in IDLE.
- A reset asserted in WAIT_RSP abandons the outstanding response; the next response from the ITCM ctrl after reset is treated as stray.

Test Plan:
- IFU only, addr 0x0010, itcm ready=1, rsp rdata 0xDEAD_BEEF_0000_0001 the next cycle -> ifu_icb_rsp_rdata matches, ext_icb_rsp_valid=0, ifu_holdup=1, next IFU accept at earliest 2 cycles after the first.
- Ext write addr 0x0020, wdata 0x1122334455667788, wmask 0x0F, with IFU idle -> downstream read=0 and fields exact; ext rsp routed; ifu_holdup 1->0.
- Both ports valid continuously with STARVE_LIM=4 -> grant sequence IFU,IFU,IFU,IFU,EXT repeating; starve_cnt returns to 0 after each EXT.
- Ext wins (IFU not valid), itcm_icb_cmd_ready held 0 for 3 cycles, IFU valid raised in cycle 1 -> downstream addr/valid stay on ext until handshake; IFU granted afterward.
- ext_lock=1 with both valid for 10 transactions -> all 10 grants go to ext, ifu_icb_cmd_ready never 1.
- rst_n=0 for 1 cycle in WAIT_RSP, then rsp_valid=1 -> both rsp_valid outputs 0, itcm_icb_rsp_ready=0, state IDLE, starve_cnt=0.
